// File: rtl/request_consumer.sv
// request_consumer: two-channel request receiver with per-channel flushable FIFOs and a round-robin merged output
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

// request_consumer_fifo: one channel buffer whose entries carry a live bit cleared by id-matched flushes
module request_consumer_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int IW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] push_address,
    input  logic [IW-1:0] push_id,
    input  logic          flush,
    input  logic [IW-1:0] flush_id,
    input  logic          pop,
    output logic          full,
    output logic          nonempty,
    output logic          head_live,
    output logic [AW-1:0] head_address,
    output logic [IW-1:0] head_id,
    output logic [7:0]    drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [IW-1:0]    id_mem   [DEPTH];
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] kill;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    off [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    kills;
    logic             push_kill;
    logic [8:0]       drop_sum;

    genvar i;
    for (i = 0; i < DEPTH; i++) begin : g_off
        assign off[i] = PW'(i) - rd_ptr;
    end

    // Flush kill mask over occupied live slots, plus the slot being written this cycle
    always_comb begin
        push_kill = push && flush && push_id == flush_id;
        kills = CW'(push_kill);
        for (int k = 0; k < DEPTH; k++) begin
            kill[k] = flush && live[k] && ({1'b0, off[k]} < count_q) && id_mem[k] == flush_id;
            kills = kills + CW'(kill[k]);
        end
    end

    assign full         = count_q == CW'(DEPTH);
    assign nonempty     = count_q != '0;
    assign head_live    = nonempty && live[rd_ptr] && !kill[rd_ptr];
    assign head_address = addr_mem[rd_ptr];
    assign head_id      = id_mem[rd_ptr];
    assign drop_sum     = {1'b0, drop_count} + 9'(kills);

    // Pointers, occupancy, live bits and the saturating drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            live       <= '0;
            drop_count <= '0;
        end else begin
            live <= live & ~kill;
            if (push) begin
                live[wr_ptr] <= !push_kill;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count_q    <= count_q + CW'(push) - CW'(pop);
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // Payload storage needs no reset; occupancy decides what is meaningful
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_address;
            id_mem[wr_ptr]   <= push_id;
        end
    end
endmodule

// request_consumer: top level, stall generation, dead-head discard and round-robin output register
module request_consumer #(
    parameter int DEPTH        = 4,
    parameter int GLOBAL_STALL = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [`ADDRESS_WIDTH-1:0] in_address_1,
    input  logic [`ID_WIDTH-1:0]      in_id_1,
    input  logic                      in_valid_1,
    output logic                      out_stall_1,
    input  logic                      flush_1,
    input  logic [`ID_WIDTH-1:0]      flush_id_1,
    input  logic [`ADDRESS_WIDTH-1:0] in_address_2,
    input  logic [`ID_WIDTH-1:0]      in_id_2,
    input  logic                      in_valid_2,
    output logic                      out_stall_2,
    input  logic                      flush_2,
    input  logic [`ID_WIDTH-1:0]      flush_id_2,
    output logic [`ADDRESS_WIDTH-1:0] out_address,
    output logic [`ID_WIDTH-1:0]      out_id,
    output logic                      out_valid,
    output logic                      out_src,
    input  logic                      in_ready,
    output logic [7:0]                drop_count_1,
    output logic [7:0]                drop_count_2
);
    localparam int AW = `ADDRESS_WIDTH;
    localparam int IW = `ID_WIDTH;

    logic          full_1, full_2, ne_1, ne_2, live_1, live_2;
    logic          push_1, push_2, pop_1, pop_2, pick_1, pick_2, load, rr;
    logic [AW-1:0] head_address_1, head_address_2;
    logic [IW-1:0] head_id_1, head_id_2;

    assign out_stall_1 = GLOBAL_STALL != 0 ? (full_1 | full_2) : full_1;
    assign out_stall_2 = GLOBAL_STALL != 0 ? (full_1 | full_2) : full_2;
    assign push_1      = in_valid_1 && !out_stall_1;
    assign push_2      = in_valid_2 && !out_stall_2;

    request_consumer_fifo #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_fifo_1 (
        .clk(clk), .reset(reset), .push(push_1), .push_address(in_address_1), .push_id(in_id_1),
        .flush(flush_1), .flush_id(flush_id_1), .pop(pop_1), .full(full_1), .nonempty(ne_1),
        .head_live(live_1), .head_address(head_address_1), .head_id(head_id_1),
        .drop_count(drop_count_1)
    );

    request_consumer_fifo #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_fifo_2 (
        .clk(clk), .reset(reset), .push(push_2), .push_address(in_address_2), .push_id(in_id_2),
        .flush(flush_2), .flush_id(flush_id_2), .pop(pop_2), .full(full_2), .nonempty(ne_2),
        .head_live(live_2), .head_address(head_address_2), .head_id(head_id_2),
        .drop_count(drop_count_2)
    );

    // Arbitration: rr=0 prefers ch1; dead heads drain independently of the output
    always_comb begin
        load   = !out_valid || in_ready;
        pick_1 = load && live_1 && (!live_2 || !rr);
        pick_2 = load && live_2 && !pick_1;
        pop_1  = (ne_1 && !live_1) || pick_1;
        pop_2  = (ne_2 && !live_2) || pick_2;
    end

    // Output register and round-robin pointer; pointer moves past the channel just served
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_src     <= 1'b0;
            out_address <= '0;
            out_id      <= '0;
            rr          <= 1'b0;
        end else if (load) begin
            out_valid <= pick_1 | pick_2;
            if (pick_1 | pick_2) begin
                out_address <= pick_1 ? head_address_1 : head_address_2;
                out_id      <= pick_1 ? head_id_1 : head_id_2;
                out_src     <= pick_2;
                rr          <= pick_1;
            end
        end
    end
endmodule
